// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL lock filter and ordered, synchronous release of per-domain resets
module pll_reset_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_CYCLES  = 1024,
    parameter int RELEASE_GAP    = 16,
    parameter int NUM_RESETS     = 3,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int PLL_RST_CYCLES = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  locked,
    input  logic                  soft_reset,
    output logic                  pll_rst,
    output logic [NUM_RESETS-1:0] rst_out,
    output logic                  ready,
    output logic [7:0]            lock_loss_count
);

    localparam int REL_SPAN = NUM_RESETS * RELEASE_GAP;
    localparam int MAX_A    = (STABLE_CYCLES > LOCK_TIMEOUT) ? STABLE_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX  = (MAX_A > REL_SPAN) ? MAX_A : REL_SPAN;
    localparam int CW       = $clog2(CNT_MAX) + 1;

    typedef enum logic [2:0] {
        PLL_RESET,
        WAIT_LOCK,
        STABLE,
        RELEASE,
        RUN
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    pll_rst_q, pll_rst_d;
    logic [NUM_RESETS-1:0]   rst_out_q, rst_out_d;
    logic                    ready_q, ready_d;
    logic [7:0]              loss_q, loss_d;
    logic                    locked_sync;

    assign locked_sync = sync_q[SYNC_STAGES-1];

    // Bit i stays asserted until the release counter reaches i*RELEASE_GAP.
    function automatic logic [NUM_RESETS-1:0] release_mask(input logic [CW-1:0] n);
        logic [NUM_RESETS-1:0] m;
        for (int i = 0; i < NUM_RESETS; i++) begin
            m[i] = (32'(n) < 32'(i * RELEASE_GAP));
        end
        return m;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= PLL_RESET;
            cnt_q     <= '0;
            sync_q    <= '0;
            pll_rst_q <= 1'b1;
            rst_out_q <= '1;
            ready_q   <= 1'b0;
            loss_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sync_q    <= {sync_q[SYNC_STAGES-2:0], locked};
            pll_rst_q <= pll_rst_d;
            rst_out_q <= rst_out_d;
            ready_q   <= ready_d;
            loss_q    <= loss_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CW'(1);
        pll_rst_d = 1'b0;
        rst_out_d = '1;
        ready_d   = 1'b0;
        loss_d    = loss_q;
        case (state_q)
            PLL_RESET: begin
                pll_rst_d = 1'b1;
                if (cnt_q == CW'(PLL_RST_CYCLES - 1)) begin
                    state_d   = WAIT_LOCK;
                    cnt_d     = '0;
                    pll_rst_d = 1'b0;
                end
            end
            WAIT_LOCK: begin
                if (soft_reset) begin
                    state_d   = PLL_RESET;
                    cnt_d     = '0;
                    pll_rst_d = 1'b1;
                end else if (locked_sync) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                    state_d   = PLL_RESET;
                    cnt_d     = '0;
                    pll_rst_d = 1'b1;
                end
            end
            STABLE: begin
                if (soft_reset) begin
                    state_d   = PLL_RESET;
                    cnt_d     = '0;
                    pll_rst_d = 1'b1;
                end else if (!locked_sync) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(STABLE_CYCLES)) begin
                    state_d   = RELEASE;
                    cnt_d     = '0;
                    rst_out_d = release_mask('0);
                end
            end
            RELEASE: begin
                if (soft_reset) begin
                    state_d   = PLL_RESET;
                    cnt_d     = '0;
                    pll_rst_d = 1'b1;
                end else if (!locked_sync) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    loss_d  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
                end else if (cnt_d == CW'(REL_SPAN)) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    rst_out_d = '0;
                    ready_d   = 1'b1;
                end else begin
                    rst_out_d = release_mask(cnt_d);
                end
            end
            RUN: begin
                cnt_d = cnt_q;
                if (soft_reset) begin
                    state_d   = PLL_RESET;
                    cnt_d     = '0;
                    pll_rst_d = 1'b1;
                end else if (!locked_sync) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    loss_d  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
                end else begin
                    rst_out_d = '0;
                    ready_d   = 1'b1;
                end
            end
            default: begin
                state_d   = PLL_RESET;
                cnt_d     = '0;
                pll_rst_d = 1'b1;
            end
        endcase
    end

    assign pll_rst         = pll_rst_q;
    assign rst_out         = rst_out_q;
    assign ready           = ready_q;
    assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - directed self-checking bench for pll_reset_sequencer
module tb_pll_reset_sequencer;

    localparam int SS  = 2;
    localparam int SC  = 8;
    localparam int RG  = 4;
    localparam int NR  = 3;
    localparam int LT  = 64;
    localparam int PRC = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          locked = 1'b0;
    logic          soft_reset = 1'b0;
    logic          pll_rst;
    logic [NR-1:0] rst_out;
    logic          ready;
    logic [7:0]    lock_loss_count;

    int n_cmp = 0;
    int n_bad = 0;

    pll_reset_sequencer #(
        .SYNC_STAGES   (SS),
        .STABLE_CYCLES (SC),
        .RELEASE_GAP   (RG),
        .NUM_RESETS    (NR),
        .LOCK_TIMEOUT  (LT),
        .PLL_RST_CYCLES(PRC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .locked         (locked),
        .soft_reset     (soft_reset),
        .pll_rst        (pll_rst),
        .rst_out        (rst_out),
        .ready          (ready),
        .lock_loss_count(lock_loss_count)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // {rst_out, ready} k edges into a sequence whose rst_out[0] falls at edge r0
    function automatic logic [3:0] rst_seq(input int k, input int r0);
        logic [2:0] ro;
        if (k < r0)             ro = 3'b111;
        else if (k < r0 + RG)   ro = 3'b110;
        else if (k < r0 + 2*RG) ro = 3'b100;
        else                    ro = 3'b000;
        return {ro, (k >= r0 + 3*RG)};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        locked = 1'b0;
        soft_reset = 1'b0;
        step(3);
        n_cmp++;
        if ({pll_rst, rst_out, ready, lock_loss_count} !== {1'b1, 3'b111, 1'b0, 8'd0}) begin
            n_bad++;
            $display("FAIL reset_values: got pll_rst=%b rst_out=%b ready=%b count=%0d, expected 1 111 0 0",
                     pll_rst, rst_out, ready, lock_loss_count);
        end
    endtask

    task automatic test_release();
        logic [4:0] exp;
        #2 rst = 1'b0;
        for (int k = 1; k <= 36; k++) begin
            step(1);
            if (k == 10) locked = 1'b1;
            exp = {(k <= 3), rst_seq(k, 22)};
            n_cmp++;
            if ({pll_rst, rst_out, ready} !== exp) begin
                n_bad++;
                $display("FAIL release edge %0d: got {pll_rst,rst_out,ready}=%b, expected %b", k, {pll_rst, rst_out, ready}, exp);
            end
        end
        n_cmp++;
        if (lock_loss_count !== 8'd0) begin
            n_bad++;
            $display("FAIL release_count: got %0d, expected 0", lock_loss_count);
        end
    endtask

    task automatic test_lock_loss();
        logic [4:0] exp;
        locked = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            step(1);
            if (k == 3) locked = 1'b1;
            exp = (k <= 2) ? 5'b0_000_1 : {1'b0, rst_seq(k, 15)};
            n_cmp++;
            if ({pll_rst, rst_out, ready} !== exp) begin
                n_bad++;
                $display("FAIL lock_loss edge %0d: got {pll_rst,rst_out,ready}=%b, expected %b", k, {pll_rst, rst_out, ready}, exp);
            end
        end
        n_cmp++;
        if (lock_loss_count !== 8'd1) begin
            n_bad++;
            $display("FAIL lock_loss_count: got %0d, expected 1", lock_loss_count);
        end
    endtask

    task automatic test_soft_reset();
        logic [4:0] exp;
        int         waited;
        locked = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            soft_reset = (k == 2 || k == 4);
            if (k <= 2)      exp = 5'b0_000_1;
            else if (k <= 6) exp = 5'b1_111_0;
            else             exp = 5'b0_111_0;
            n_cmp++;
            if ({pll_rst, rst_out, ready} !== exp) begin
                n_bad++;
                $display("FAIL soft_reset edge %0d: got {pll_rst,rst_out,ready}=%b, expected %b", k, {pll_rst, rst_out, ready}, exp);
            end
        end
        n_cmp++;
        if (lock_loss_count !== 8'd1) begin
            n_bad++;
            $display("FAIL soft_reset_count: got %0d, expected 1", lock_loss_count);
        end
        locked = 1'b1;
        waited = 0;
        while (!ready && waited < 200) begin
            step(1);
            waited++;
        end
        n_cmp++;
        if (ready !== 1'b1) begin
            n_bad++;
            $display("FAIL soft_reset_recover: ready=%b after %0d cycles, expected 1", ready, waited);
        end
    endtask

    task automatic test_saturation();
        logic [7:0] exp_cnt;
        for (int i = 0; i < 299; i++) begin
            locked = 1'b0;
            step(3);
            exp_cnt = (i + 2 > 255) ? 8'd255 : 8'(i + 2);
            n_cmp++;
            if (lock_loss_count !== exp_cnt || rst_out !== 3'b111 || ready !== 1'b0) begin
                n_bad++;
                $display("FAIL saturation loss %0d: got count=%0d rst_out=%b ready=%b, expected count=%0d rst_out=111 ready=0",
                         i + 2, lock_loss_count, rst_out, ready, exp_cnt);
            end
            locked = 1'b1;
            step(24);
            n_cmp++;
            if (ready !== 1'b1 || rst_out !== 3'b000) begin
                n_bad++;
                $display("FAIL saturation rerelease %0d: got ready=%b rst_out=%b, expected 1 000", i + 2, ready, rst_out);
            end
        end
    endtask

    task automatic test_async_reset();
        locked = 1'b0;
        step(3);
        locked = 1'b1;
        step(12);
        n_cmp++;
        if (rst_out !== 3'b110 || lock_loss_count !== 8'd255) begin
            n_bad++;
            $display("FAIL async_pre: got rst_out=%b count=%0d, expected 110 255", rst_out, lock_loss_count);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({pll_rst, rst_out, ready, lock_loss_count} !== {1'b1, 3'b111, 1'b0, 8'd0}) begin
            n_bad++;
            $display("FAIL async_reset: got pll_rst=%b rst_out=%b ready=%b count=%0d, expected 1 111 0 0",
                     pll_rst, rst_out, ready, lock_loss_count);
        end
        step(2);
    endtask

    task automatic test_glitch();
        logic [4:0] exp;
        locked = 1'b0;
        #2 rst = 1'b0;
        for (int k = 1; k <= 42; k++) begin
            step(1);
            if (k == 10) locked = 1'b1;
            if (k == 16) locked = 1'b0;
            if (k == 17) locked = 1'b1;
            exp = {(k <= 3), rst_seq(k, 29)};
            n_cmp++;
            if ({pll_rst, rst_out, ready} !== exp) begin
                n_bad++;
                $display("FAIL glitch edge %0d: got {pll_rst,rst_out,ready}=%b, expected %b", k, {pll_rst, rst_out, ready}, exp);
            end
        end
        n_cmp++;
        if (lock_loss_count !== 8'd0) begin
            n_bad++;
            $display("FAIL glitch_count: got %0d, expected 0", lock_loss_count);
        end
    endtask

    task automatic test_timeout();
        logic [4:0] exp;
        rst = 1'b1;
        locked = 1'b0;
        step(2);
        #2 rst = 1'b0;
        for (int k = 1; k <= 150; k++) begin
            step(1);
            exp = {((k % (PRC + LT)) < PRC), 3'b111, 1'b0};
            n_cmp++;
            if ({pll_rst, rst_out, ready} !== exp) begin
                n_bad++;
                $display("FAIL timeout edge %0d: got {pll_rst,rst_out,ready}=%b, expected %b", k, {pll_rst, rst_out, ready}, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_release();
        test_lock_loss();
        test_soft_reset();
        test_saturation();
        test_async_reset();
        test_glitch();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
